// File: rtl/matrix_b_skew_feeder_if.sv
// Bundle between the B column extractor / array control and the skew feeder.
// Handshake: a load is accepted on a rising edge where load_valid && load_ready;
// load_ready is high only while the feeder is idle, and load_valid has no effect otherwise.
interface matrix_b_skew_feeder_if #(
  parameter int K          = 6,
  parameter int N          = 6,
  parameter int DATA_WIDTH = 16
);
  logic                        load_valid;
  logic                        load_ready;
  logic [N*K*DATA_WIDTH-1:0]   columns_flat;
  logic                        en;
  logic [N*DATA_WIDTH-1:0]     b_out;
  logic [N-1:0]                b_col_valid;
  logic                        busy;
  logic                        done;
  logic [1:0]                  dbg_state;

  modport master (
    output load_valid, columns_flat, en,
    input  load_ready, b_out, b_col_valid, busy, done, dbg_state
  );

  modport slave (
    input  load_valid, columns_flat, en,
    output load_ready, b_out, b_col_valid, busy, done, dbg_state
  );
endinterface

// File: rtl/matrix_b_skew_feeder.sv
// Captures one column-major K x N B matrix and streams it into the systolic array
// top edge one diagonal wavefront per enabled cycle (column c delayed by c steps).
module matrix_b_skew_feeder #(
  parameter int K          = 6,
  parameter int N          = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  matrix_b_skew_feeder_if.slave io_bus
);
  localparam int S  = K + N - 1;
  localparam int TW = $clog2(K + N);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_next_state;
  logic [TW-1:0]               r_t;
  logic [N*K*DATA_WIDTH-1:0]   r_buf;
  logic [N*DATA_WIDTH-1:0]     r_b_out;
  logic [N*DATA_WIDTH-1:0]     w_step_data;
  logic [N-1:0]                r_valid;
  logic [N-1:0]                w_step_valid;
  logic                        r_done;
  logic                        w_load_ready;
  logic                        w_busy;
  logic                        w_accept;
  logic                        w_last;

  assign w_accept = io_bus.load_valid && w_load_ready;
  assign w_last   = (r_t == TW'(S - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next_state = ST_STREAM;
      ST_STREAM: if (io_bus.en && w_last) w_next_state = ST_DRAIN;
      ST_DRAIN:  w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from state only
  always_comb begin
    w_load_ready = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      ST_IDLE:   w_load_ready = 1'b1;
      ST_STREAM: w_busy       = 1'b1;
      ST_DRAIN:  w_busy       = 1'b1;
      default:   w_load_ready = 1'b1;
    endcase
  end

  // Wavefront for step t: lane c carries B[t-c][c] when that row exists.
  always_comb begin
    w_step_data  = '0;
    w_step_valid = '0;
    for (int c = 0; c < N; c++) begin
      if ((int'(r_t) >= c) && ((int'(r_t) - c) < K)) begin
        w_step_data[c*DATA_WIDTH +: DATA_WIDTH] =
          r_buf[(c*K + int'(r_t) - c)*DATA_WIDTH +: DATA_WIDTH];
        w_step_valid[c] = 1'b1;
      end
    end
  end

  // Matrix buffer has no reset; it is only meaningful after an accepted load.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf <= io_bus.columns_flat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t     <= '0;
      r_b_out <= '0;
      r_valid <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) r_t <= '0;
        end
        ST_STREAM: begin
          if (io_bus.en) begin
            r_b_out <= w_step_data;
            r_valid <= w_step_valid;
            if (w_last) begin
              r_done <= 1'b1;
            end else begin
              r_t <= r_t + TW'(1);
            end
          end
        end
        ST_DRAIN: begin
          r_b_out <= '0;
          r_valid <= '0;
          r_done  <= 1'b0;
        end
        default: begin
          r_b_out <= '0;
          r_valid <= '0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.load_ready  = w_load_ready;
  assign io_bus.busy        = w_busy;
  assign io_bus.b_out       = r_b_out;
  assign io_bus.b_col_valid = r_valid;
  assign io_bus.done        = r_done;
  assign io_bus.dbg_state   = r_state;
endmodule

// File: tb/tb_matrix_b_skew_feeder.sv
// Bench for matrix_b_skew_feeder: 3x3 instance driven through a scoreboard, plus
// K=1/N=4 and K=4/N=1 instances exercised with hand-derived step expectations.
module tb_matrix_b_skew_feeder;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_b_skew_feeder_if #(.K(3), .N(3), .DATA_WIDTH(DW)) bif ();
  matrix_b_skew_feeder_if #(.K(1), .N(4), .DATA_WIDTH(DW)) kif ();
  matrix_b_skew_feeder_if #(.K(4), .N(1), .DATA_WIDTH(DW)) nif ();

  matrix_b_skew_feeder #(.K(3), .N(3), .DATA_WIDTH(DW)) u_dut (.clk(clk), .rst(rst), .io_bus(bif));
  matrix_b_skew_feeder #(.K(1), .N(4), .DATA_WIDTH(DW)) u_k1  (.clk(clk), .rst(rst), .io_bus(kif));
  matrix_b_skew_feeder #(.K(4), .N(1), .DATA_WIDTH(DW)) u_n1  (.clk(clk), .rst(rst), .io_bus(nif));

  typedef struct packed {
    logic [47:0] b_out;
    logic [2:0]  valid;
    logic        done;
    logic        ready;
    logic        busy;
  } obs_t;

  typedef struct {
    int          step;
    logic [47:0] b_out;
    logic [2:0]  valid;
    logic        done;
  } vec_t;

  obs_t        exp_q[$];
  vec_t        basic_tbl[5];
  logic [47:0] cur_so[5];
  logic [2:0]  cur_sv[5];
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic logic [47:0] lanes3(input int a, input int b, input int c);
    return {16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic obs_t sample3();
    return {bif.b_out, bif.b_col_valid, bif.done, bif.load_ready, bif.busy};
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got b_out=%h valid=%b done=%b ready=%b busy=%b, required b_out=%h valid=%b done=%b ready=%b busy=%b",
               name, act.b_out, act.valid, act.done, act.ready, act.busy,
               exp.b_out, exp.valid, exp.done, exp.ready, exp.busy);
    end
  endtask

  task automatic check_gen(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // One clock edge, then compare the settled outputs with the next scoreboard entry.
  task automatic tick_check(input string name);
    obs_t e;
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check_obs(name, sample3(), e);
    end
  endtask

  task automatic model3(input logic [143:0] mat);
    logic [15:0] b[3][3];
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        b[r][c] = mat[(c*3 + r)*16 +: 16];
    for (int s = 0; s < 5; s++) begin
      cur_so[s] = '0;
      cur_sv[s] = '0;
      for (int c = 0; c < 3; c++) begin
        if ((s - c) >= 0 && (s - c) < 3) begin
          cur_so[s][c*16 +: 16] = b[s-c][c];
          cur_sv[s][c] = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [143:0] rand_mat();
    logic [143:0] m;
    for (int i = 0; i < 9; i++) m[i*16 +: 16] = 16'($urandom_range(1, 65535));
    return m;
  endfunction

  // Load mat at the next edge and stream it, with an optional stall while step 2
  // is showing, an optional foreign load pulse at edge E0+intrude_k, en low on the
  // drain edge, and optionally next_mat presented through the drain edge.
  task automatic run3(input string name, input logic [143:0] mat, input int stall_len,
                      input int intrude_k, input logic [143:0] other_mat,
                      input bit en_lo_drain, input bit chain);
    int last_k;
    last_k = 5 + stall_len + 1;
    exp_q.push_back({48'h0, 3'b000, 1'b0, 1'b0, 1'b1});
    for (int s = 0; s < 5; s++)
      for (int rep = 0; rep <= ((s == 2) ? stall_len : 0); rep++)
        exp_q.push_back({cur_so[s], cur_sv[s], (s == 4), 1'b0, 1'b1});
    exp_q.push_back({48'h0, 3'b000, 1'b0, 1'b1, 1'b0});

    bif.load_valid   = 1'b1;
    bif.columns_flat = mat;
    bif.en           = 1'b1;
    tick_check({name, "_accept"});
    bif.load_valid   = 1'b0;
    bif.columns_flat = other_mat;
    for (int k = 1; k <= last_k; k++) begin
      bif.en = !(stall_len > 0 && k >= 4 && k < 4 + stall_len);
      bif.load_valid = (k == intrude_k);
      if (k == last_k) begin
        bif.en = !en_lo_drain;
        if (chain) bif.load_valid = 1'b1;
      end
      tick_check($sformatf("%s_k%0d", name, k));
    end
    if (!chain) bif.load_valid = 1'b0;
  endtask

  logic [143:0] basic_mat;
  logic [143:0] mat_a;
  logic [143:0] mat_b;

  initial begin
    basic_tbl[0] = '{0, lanes3(1, 0, 0), 3'b001, 1'b0};
    basic_tbl[1] = '{1, lanes3(4, 2, 0), 3'b011, 1'b0};
    basic_tbl[2] = '{2, lanes3(7, 5, 3), 3'b111, 1'b0};
    basic_tbl[3] = '{3, lanes3(0, 8, 6), 3'b110, 1'b0};
    basic_tbl[4] = '{4, lanes3(0, 0, 9), 3'b100, 1'b1};
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        basic_mat[(c*3 + r)*16 +: 16] = 16'(r*3 + c + 1);

    bif.load_valid = 1'b0; bif.columns_flat = '0; bif.en = 1'b0;
    kif.load_valid = 1'b0; kif.columns_flat = '0; kif.en = 1'b0;
    nif.load_valid = 1'b0; nif.columns_flat = '0; nif.en = 1'b0;

    // Reset asserted before any clock edge
    #3;
    check_obs("reset_3x3", sample3(), {48'h0, 3'b000, 1'b0, 1'b1, 1'b0});
    check_gen("reset_k1", 128'({kif.b_out, kif.b_col_valid, kif.done, kif.load_ready, kif.busy}),
              128'({64'h0, 4'b0, 1'b0, 1'b1, 1'b0}));
    check_gen("reset_n1", 128'({nif.b_out, nif.b_col_valid, nif.done, nif.load_ready, nif.busy}),
              128'({16'h0, 1'b0, 1'b0, 1'b1, 1'b0}));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic stream from the table; table entries feed the scoreboard in order.
    for (int i = 0; i < 5; i++) begin
      cur_so[basic_tbl[i].step] = basic_tbl[i].b_out;
      cur_sv[basic_tbl[i].step] = basic_tbl[i].valid;
    end
    run3("basic", basic_mat, 0, 0, '0, 1'b0, 1'b0);

    // Stall two cycles on step 2, en low on the drain edge
    run3("stall", basic_mat, 2, 0, '0, 1'b1, 1'b0);

    // Foreign load during STREAM is ignored; mat_a held through drain
    mat_a = rand_mat();
    run3("intrude", basic_mat, 0, 2, mat_a, 1'b0, 1'b1);
    model3(mat_a);
    run3("b2b", mat_a, 0, 3, rand_mat(), 1'b0, 1'b0);

    // Mid-stream asynchronous reset while step 2 is showing
    mat_b = rand_mat();
    model3(mat_b);
    exp_q.push_back({48'h0, 3'b000, 1'b0, 1'b0, 1'b1});
    for (int s = 0; s < 3; s++) exp_q.push_back({cur_so[s], cur_sv[s], 1'b0, 1'b0, 1'b1});
    bif.load_valid = 1'b1; bif.columns_flat = mat_b; bif.en = 1'b1;
    tick_check("rstmid_accept");
    bif.load_valid = 1'b0;
    for (int k = 1; k <= 3; k++) tick_check($sformatf("rstmid_k%0d", k));
    #2 rst = 1'b1;
    #1 check_obs("rstmid_async", sample3(), {48'h0, 3'b000, 1'b0, 1'b1, 1'b0});
    @(posedge clk);
    @(negedge clk);
    check_obs("rstmid_held", sample3(), {48'h0, 3'b000, 1'b0, 1'b1, 1'b0});
    exp_q.delete();
    rst = 1'b0;
    mat_b = rand_mat();
    model3(mat_b);
    run3("after_rst", mat_b, 0, 0, '0, 1'b0, 1'b0);

    // Degenerate shapes: K=1/N=4 walks one valid lane; K=4/N=1 streams lane 0.
    kif.columns_flat = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
    nif.columns_flat = {16'h0023, 16'h0022, 16'h0021, 16'h0020};
    kif.load_valid = 1'b1; kif.en = 1'b1;
    nif.load_valid = 1'b1; nif.en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kif.load_valid = 1'b0;
    nif.load_valid = 1'b0;
    check_gen("k1_accept", 128'({kif.busy, kif.load_ready}), 128'(2'b10));
    check_gen("n1_accept", 128'({nif.busy, nif.load_ready}), 128'(2'b10));
    for (int s = 0; s < 4; s++) begin
      logic [63:0] eb;
      logic [3:0]  ev;
      @(posedge clk);
      @(negedge clk);
      eb = '0;
      eb[s*16 +: 16] = 16'h0010 + 16'(s);
      ev = 4'b0001 << s;
      check_gen($sformatf("k1_step%0d", s),
                128'({kif.b_out, kif.b_col_valid, kif.done}), 128'({eb, ev, (s == 3)}));
      check_gen($sformatf("n1_step%0d", s),
                128'({nif.b_out, nif.b_col_valid, nif.done}),
                128'({16'h0020 + 16'(s), 1'b1, (s == 3)}));
    end
    @(posedge clk);
    @(negedge clk);
    check_gen("k1_drain", 128'({kif.b_out, kif.b_col_valid, kif.done, kif.load_ready, kif.busy}),
              128'({64'h0, 4'b0, 1'b0, 1'b1, 1'b0}));
    check_gen("n1_drain", 128'({nif.b_out, nif.b_col_valid, nif.done, nif.load_ready, nif.busy}),
              128'({16'h0, 1'b0, 1'b0, 1'b1, 1'b0}));

    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/matrix_b_skew_feeder.md
# matrix_b_skew_feeder

Sequential stage directly downstream of the B-matrix column extractor. It captures one column-major B matrix (K×N, element B[r][c] at column-major index c*K+r), then streams it into the top edge of the systolic array one row-wavefront per cycle. Column c is delayed by c cycles (diagonal skew), so the array's processing elements receive correctly aligned operands. Streaming stalls under an upstream/array enable.

## Interface
Parameters:
- K, 6, rows of B (reduction depth), K ≥ 1
- N, 6, columns of B (array width), N ≥ 1
- DATA_WIDTH, 16, bits per element

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- load_valid  in  1  columns_flat holds a valid matrix
- load_ready  out  1  high only in IDLE; a load is accepted on an edge where load_valid && load_ready
- columns_flat  in  N*K*DATA_WIDTH  column-major B; element (r,c) at bits [(c*K+r)*DATA_WIDTH +: DATA_WIDTH]
- en  in  1  advance enable; low freezes streaming
- b_out  out  N*DATA_WIDTH  lane c at [c*DATA_WIDTH +: DATA_WIDTH], registered
- b_col_valid  out  N  bit c = lane c carries a real element, registered
- busy  out  1  high in STREAM and DRAIN
- done  out  1  one-cycle pulse, high while the last wavefront is on the outputs

## Operation
- Storage: one N*K*DATA_WIDTH buffer register, written only on an accepted load.
- Step counter t, width clog2(K+N), range 0..S-1, where S = K+N-1.
- Step s output: lane c = B[s-c][c] with valid bit 1 if 0 ≤ s-c < K; otherwise lane = 0 with valid bit 0.
- States:
  - IDLE: load_ready=1. On accept, latch the buffer, t←0, go to STREAM. load_valid in any other state is ignored; the buffer does not change.
  - STREAM, edge with en=1: outputs←step t. If t==S-1, done←1 and go to DRAIN. Otherwise t←t+1.
  - STREAM, edge with en=0: outputs, t and done hold.
  - DRAIN: at the next edge, regardless of en: b_out←0, b_col_valid←0, done←0, go to IDLE.
- load_ready is combinational from state. busy = (state != IDLE).
- Reset, asynchronous and effective at any time including mid-stream: state=IDLE, t=0, b_out=0, b_col_valid=0, done=0, busy=0, load_ready=1. The buffer is not reset; its contents are don't-care.

## Timing
- Accept edge E0. With en held high, step s is visible in the cycle after edge E0+1+s.
  - First valid data appears 2 edges after the load.
  - done is high with step S-1, after edge E0+S.
  - load_ready returns high after edge E0+S+1.
- Each cycle of en low inside STREAM adds one cycle of latency. en is a don't-care in IDLE and DRAIN.
- Throughput: one matrix per S+2 cycles. A back-to-back load is accepted on the first IDLE edge.
- Outputs are all registered. No combinational path from columns_flat to b_out.
- K=1 or N=1: S is still K+N-1. K=N=1 gives S=1: done is high on the first and only step.

## Test plan
- Reset values: assert rst mid-cycle, no clock edge -> all outputs at reset values immediately, load_ready=1.
- Basic stream, K=N=3, DATA_WIDTH=16, B[r][c]=r*3+c+1, en=1. Required (lane0,lane1,lane2 / valid bits {c2,c1,c0}):
  - step 0: (1,0,0) / 001
  - step 1: (4,2,0) / 011
  - step 2: (7,5,3) / 111
  - step 3: (0,8,6) / 110
  - step 4: (0,0,9) / 100, done=1
  - next cycle: all zero, load_ready=1
- Stall: same matrix, en=0 for 2 cycles while step 2 is showing -> (7,5,3) held 3 cycles total; done arrives 2 cycles later.
- Load while busy: pulse load_valid with a different matrix during STREAM -> ignored, output sequence unchanged. A back-to-back load held through DRAIN is accepted on the first IDLE edge.
- Mid-stream reset: assert rst during step 2 -> outputs 0 asynchronously. After release, a new load streams correctly from step 0.
- Degenerate sizes: K=1, N=4 -> 4 steps, each with a single valid lane walking from lane 0 to lane 3. K=4, N=1 -> lane 0 outputs B[0..3][0] over 4 steps, done on step 3.
